// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen_if
// Description : Pixel-stream / window-output bundle for the 3x3 window generator
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_gen_if;
    logic         start_i;
    logic [7:0]   pix_i;
    logic         pix_vld_i;
    logic [127:0] din_o;
    logic         vld_o;
    logic [15:0]  row_o;
    logic [15:0]  col_o;
    logic         busy_o;
    logic         frame_done_o;

    modport master (
        output start_i, pix_i, pix_vld_i,
        input  din_o, vld_o, row_o, col_o, busy_o, frame_done_o
    );

    modport slave (
        input  start_i, pix_i, pix_vld_i,
        output din_o, vld_o, row_o, col_o, busy_o, frame_done_o
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Streaming zero-padded 3x3 window generator feeding the MAC array
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
    parameter int IFM_WIDTH  = 256,
    parameter int IFM_HEIGHT = 256,
    parameter int DW         = 8
) (
    input wire               clk,
    input wire               rstn,
    conv_window_gen_if.slave bus
);
    localparam int c_NPIX = IFM_WIDTH * IFM_HEIGHT;
    localparam int c_KW   = $clog2(c_NPIX + 1);
    localparam int c_PW   = $clog2(IFM_WIDTH);

    localparam logic [c_KW-1:0] c_K_FIRST  = c_KW'(IFM_WIDTH + 1);
    localparam logic [c_KW-1:0] c_K_LAST   = c_KW'(c_NPIX - 1);
    localparam logic [c_PW-1:0] c_P_LAST   = c_PW'(IFM_WIDTH - 1);
    localparam logic [15:0]     c_LAST_COL = 16'(IFM_WIDTH - 1);
    localparam logic [15:0]     c_LAST_ROW = 16'(IFM_HEIGHT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FILL  = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_FLUSH = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]      r_state, w_state_nxt;
    logic [c_KW-1:0] r_kin;
    logic [c_PW-1:0] r_ptr;
    logic [15:0]     r_crow, r_ccol;
    logic [DW-1:0]   r_lb0 [IFM_WIDTH];
    logic [DW-1:0]   r_lb1 [IFM_WIDTH];
    logic [DW-1:0]   r_win [9];
    logic [DW-1:0]   w_nxt [9];
    logic [127:0]    r_din, w_din;
    logic            r_vld, r_busy, r_frame_done;
    logic [15:0]     r_row, r_col;
    logic            w_start, w_accept, w_flush, w_emit, w_adv, w_last_ctr;
    logic [DW-1:0]   w_pix_in, w_lb0_rd, w_lb1_rd;

    assign w_last_ctr = (r_crow == c_LAST_ROW) && (r_ccol == c_LAST_COL);
    assign w_adv      = w_accept | w_flush;
    assign w_pix_in   = w_accept ? bus.pix_i : '0;
    assign w_lb0_rd   = r_lb0[r_ptr];
    assign w_lb1_rd   = r_lb1[r_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_flush     = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // a start coinciding with frame_done_o belongs to the old frame
                if (bus.start_i && !r_frame_done) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                if (bus.pix_vld_i) begin
                    w_accept = 1'b1;
                    if (r_kin == c_K_FIRST) begin
                        w_emit      = 1'b1;
                        w_state_nxt = (r_kin == c_K_LAST) ? c_ST_FLUSH : c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                if (bus.pix_vld_i) begin
                    w_accept = 1'b1;
                    w_emit   = 1'b1;
                    if (r_kin == c_K_LAST) begin
                        w_state_nxt = c_ST_FLUSH;
                    end
                end
            end
            c_ST_FLUSH: begin
                w_flush = 1'b1;
                w_emit  = 1'b1;
                if (w_last_ctr) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Window after this cycle's shift: right column is the newest pixel of each row.
    always_comb begin
        w_nxt[0] = r_win[1];
        w_nxt[1] = r_win[2];
        w_nxt[2] = w_lb1_rd;
        w_nxt[3] = r_win[4];
        w_nxt[4] = r_win[5];
        w_nxt[5] = w_lb0_rd;
        w_nxt[6] = r_win[7];
        w_nxt[7] = r_win[8];
        w_nxt[8] = w_pix_in;
    end

    // Border masks also hide wrapped or stale pixels from neighbouring rows/frames.
    always_comb begin
        w_din = '0;
        for (int i = 0; i < 9; i++) begin
            if (!(((i < 3) && (r_crow == 16'd0)) ||
                  ((i > 5) && (r_crow == c_LAST_ROW)) ||
                  (((i % 3) == 0) && (r_ccol == 16'd0)) ||
                  (((i % 3) == 2) && (r_ccol == c_LAST_COL)))) begin
                w_din[i*DW +: DW] = w_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_lb0[r_ptr] <= w_pix_in;
            r_lb1[r_ptr] <= w_lb0_rd;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= w_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_ST_IDLE;
            r_kin        <= '0;
            r_ptr        <= '0;
            r_crow       <= '0;
            r_ccol       <= '0;
            r_din        <= '0;
            r_vld        <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vld        <= w_emit;
            r_busy       <= (w_state_nxt != c_ST_IDLE);
            r_frame_done <= (r_state == c_ST_DONE);
            if (w_start) begin
                r_kin  <= '0;
                r_ptr  <= '0;
                r_crow <= '0;
                r_ccol <= '0;
            end
            if (w_accept) begin
                r_kin <= r_kin + 1'b1;
            end
            if (w_adv) begin
                r_ptr <= (r_ptr == c_P_LAST) ? '0 : r_ptr + 1'b1;
            end
            if (w_emit) begin
                r_din <= w_din;
                r_row <= r_crow;
                r_col <= r_ccol;
                if (r_ccol == c_LAST_COL) begin
                    r_ccol <= '0;
                    r_crow <= r_crow + 16'd1;
                end else begin
                    r_ccol <= r_ccol + 16'd1;
                end
            end
        end
    end

    assign bus.din_o        = r_din;
    assign bus.vld_o        = r_vld;
    assign bus.row_o        = r_row;
    assign bus.col_o        = r_col;
    assign bus.busy_o       = r_busy;
    assign bus.frame_done_o = r_frame_done;
endmodule
`default_nettype wire
